uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
- Parametrised next-generation UART receiver.
- Adds configurable data width and oversampling, runtime parity mode (none/even/odd), 1 or 2 stop bits, 3-sample majority voting, false-start rejection and break detection.
- Adds a valid/ready output handshake with overrun reporting.
- Sits between the pad-side serial line and the receive FIFO/host logic; advances only on an external oversample-rate tick from the shared baud generator.

Parameters:
- DATA_BITS, 8, data bits per frame (legal 5..9), LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, legal 8..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-cycle pulse at OVERSAMPLE x baud rate.
- RxD  in  1  raw serial line, idle high, asynchronous to clk.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- two_stop  in  1  1 = two stop bits expected.
- RxData  out  DATA_BITS  received word, held while rx_valid=1.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts word when rx_valid&rx_ready.
- Parity_error  out  1  parity mismatch for the word on RxData (qualified by rx_valid).
- Stop_error  out  1  framing error (any stop sample 0) for the word on RxData.
- overrun  out  1  one-cycle pulse: completed frame dropped.
- break_det  out  1  one-cycle pulse: break condition received.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; RxData 0; internal synchroniser flops 1; state IDLE. Reset mid-frame aborts the frame with no flags.
- RxD passes through a 2-flop synchroniser (reset to 1). All counters and state advance only on cycles with baud_tick=1.
- Bit sampling: tick counter t runs 0..OVERSAMPLE-1 per bit. With M=OVERSAMPLE/2, samples are taken at t=M-1, M, M+1; the bit value is the majority of the three, resolved at t=M+1.
- States:
  - IDLE: synced line 0 on a tick -> START with t=1.
  - START: majority at M+1; if 1 -> IDLE (false start, no flag), else continue; at t=OVERSAMPLE-1 -> DATA.
  - DATA: shift majority into bit[n], LSB first; after bit DATA_BITS-1 -> PARITY if parity enabled, else STOP1.
  - PARITY: even mode requires ^data==bit; odd mode requires ^data!=bit. A mismatch sets the pending parity flag; the frame continues (no abort).
  - STOP1: majority resolved at M+1. If two_stop=0, the frame completes at this point and goes to IDLE (early completion for resync). If two_stop=1, advance to STOP2 at t=OVERSAMPLE-1.
  - STOP2: completes at its M+1 and goes to IDLE.
  - BRK_WAIT: -> IDLE when the synced line is 1 on a tick.
- parity_mode and two_stop are captured at start detection; changes mid-frame are ignored.
- Completion: the pending error flags are any stop sample 0 (framing) and the parity mismatch.
- Break: data all 0, parity sample 0 if enabled, and first stop 0. On break, break_det pulses on the cycle after completion, no word is delivered, and the state goes to BRK_WAIT.
- Delivery (non-break): rx_valid, RxData, Parity_error and Stop_error are updated the clk cycle after the completing tick.
- Holding register:
  - Handshake: transfer when rx_valid&rx_ready. rx_valid drops the next cycle unless a new word loads.
  - If the holding register is occupied and not being accepted on the completion cycle, the new word is dropped, overrun pulses 1 cycle, and the held word and flags are unchanged.
  - If rx_ready=1 on the completion cycle, the new word loads and rx_valid stays 1 (no overrun).
- Widths: t is clog2(OVERSAMPLE) bits; bit counter is clog2(DATA_BITS+1) bits. Both reset to 0 on every state change.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - Parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - Shared by the future matching transmitter.
- One sub-module, uart_bit_sampler: 2-flop synchroniser plus 3-sample majority voter, driven by t and baud_tick. It outputs synced_rxd and bit_value, with bit_strobe at M+1.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, parity none, one stop; send 0xA5; rx_ready=1 -> rx_valid pulses once with RxData=0xA5, both errors 0.
- Even parity; send 0x3C with parity bit 1 -> word 0x3C delivered with Parity_error=1. Repeat with odd parity and parity bit 1 -> Parity_error=0.
- two_stop=1; send 0x55 with second stop bit 0 -> RxData=0x55, Stop_error=1. A 2-tick low glitch on idle line -> no rx_valid and no flags (false start rejected).
- rx_ready=0; send 0x11 then 0x22 -> RxData stays 0x11, overrun pulses once at end of the 0x22 frame. Raise rx_ready exactly on the second completion cycle instead -> 0x22 loaded, no overrun.
- Hold RxD low for 20 bit times -> break_det pulses once, rx_valid stays 0. Line returns high, then send 0x7E -> 0x7E delivered correctly.
- Assert reset mid-DATA of 0xFF, release, then send 0x01 -> outputs 0 during reset, only 0x01 delivered. Single-tick noise on the centre sample of each data bit of 0x0F -> 0x0F still received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity-mode constants shared by the UART receiver and transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: two-flop line synchroniser and 3-sample majority voter around the bit centre.
module uart_bit_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int TW = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          baud_tick,
    input  logic          rxd,
    input  logic [TW-1:0] t,
    output logic          synced_rxd,
    output logic          bit_value,
    output logic          bit_strobe
);
    localparam logic [TW-1:0] M0 = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] M1 = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] M2 = TW'(OVERSAMPLE/2 + 1);
    logic meta, s0, s1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {meta, synced_rxd, s0, s1} <= '1;
        end else begin
            {synced_rxd, meta} <= {meta, rxd};
            if (baud_tick && t == M0) s0 <= synced_rxd;
            if (baud_tick && t == M1) s1 <= synced_rxd;
        end
    end
    // third vote is the live synced line, so the result is valid on the M+1 tick itself
    assign bit_value  = (s0 & s1) | (s0 & synced_rxd) | (s1 & synced_rxd);
    assign bit_strobe = baud_tick && t == M2;
endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with parity, 1/2 stop bits, break detection and valid/ready output.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 RxD,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 Parity_error,
    output logic                 Stop_error,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] N_LAST = CW'(DATA_BITS);
    state_t state, state_n;
    logic [TW-1:0] t;
    logic [CW-1:0] n;
    logic [DATA_BITS-1:0] data;
    logic [1:0] pm;
    logic ts, par_err, par_bit, stop1_low;
    logic synced, bit_value, strobe, bit_end, par_en, complete, is_break, first_stop_low, frame_serr;

    uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE), .TW(TW)) u_sampler (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rxd(RxD), .t(t),
        .synced_rxd(synced), .bit_value(bit_value), .bit_strobe(strobe)
    );

    assign bit_end        = baud_tick && t == T_LAST;
    assign par_en         = pm == PAR_EVEN || pm == PAR_ODD;
    assign first_stop_low = (state == STOP1) ? !bit_value : stop1_low;
    assign frame_serr     = first_stop_low | !bit_value;
    assign is_break       = data == '0 && (!par_en || !par_bit) && first_stop_low;

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        case (state)
            IDLE:     state_n = (baud_tick && !synced) ? START : IDLE;
            START:    state_n = (strobe && bit_value) ? IDLE : bit_end ? DATA : START;
            DATA:     state_n = (bit_end && n == N_LAST) ? (par_en ? PARITY : STOP1) : DATA;
            PARITY:   state_n = bit_end ? STOP1 : PARITY;
            STOP1: begin
                complete = strobe && !ts;
                state_n  = complete ? (is_break ? BRK_WAIT : IDLE) : (bit_end && ts) ? STOP2 : STOP1;
            end
            STOP2: begin
                complete = strobe;
                state_n  = complete ? (is_break ? BRK_WAIT : IDLE) : STOP2;
            end
            BRK_WAIT: state_n = (baud_tick && synced) ? IDLE : BRK_WAIT;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {t, n, data, pm, ts, par_err, par_bit, stop1_low} <= '0;
        end else if (baud_tick) begin
            // the detecting tick counts as t=0 of the start bit
            t <= (state_n != state) ? ((state_n == START) ? TW'(1) : '0) : (t == T_LAST) ? '0 : t + 1'b1;
            n <= (state_n != state) ? '0 : (strobe && state == DATA) ? n + 1'b1 : n;
            if (state == IDLE && state_n == START) begin
                pm <= parity_mode;
                ts <= two_stop;
                {par_err, par_bit, stop1_low} <= '0;
            end
            if (strobe && state == DATA) data <= {bit_value, data[DATA_BITS-1:1]};
            if (strobe && state == PARITY) begin
                par_bit <= bit_value;
                par_err <= (pm == PAR_EVEN) ? (^data != bit_value) : (^data == bit_value);
            end
            if (strobe && state == STOP1) stop1_low <= !bit_value;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_valid, RxData, Parity_error, Stop_error, overrun, break_det} <= '0;
        end else begin
            overrun   <= complete && !is_break && rx_valid && !rx_ready;
            break_det <= complete && is_break;
            if (complete && !is_break && !(rx_valid && !rx_ready)) begin
                rx_valid     <= 1'b1;
                RxData       <= data;
                Parity_error <= par_err;
                Stop_error   <= frame_serr;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed scenario tests for uart_rx_ext at 8 data bits, 16x oversampling.
module tb_uart_rx_ext;
    logic clk = 0, reset = 0, RxD = 1, two_stop = 0, rx_ready = 1;
    logic [1:0] parity_mode = 2'b00;
    logic [1:0] div = 0;
    logic baud_tick;
    logic [7:0] RxData;
    logic rx_valid, Parity_error, Stop_error, overrun, break_det;
    int cmp = 0, bad = 0;
    int tick_cnt = 0, acc_cnt = 0, ovr_cnt = 0, brk_cnt = 0;
    logic [7:0] acc_data = 0;
    logic acc_perr = 0, acc_serr = 0;

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .RxD(RxD), .parity_mode(parity_mode),
        .two_stop(two_stop), .RxData(RxData), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .Parity_error(Parity_error), .Stop_error(Stop_error), .overrun(overrun), .break_det(break_det)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign baud_tick = (div == 2'd0);

    always @(negedge clk) begin
        if (baud_tick) tick_cnt++;
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            acc_data = RxData;
            acc_perr = Parity_error;
            acc_serr = Stop_error;
        end
        if (overrun) ovr_cnt++;
        if (break_det) brk_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int k);
        int target;
        target = tick_cnt + k;
        while (tick_cnt < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_head(input logic [7:0] d, input logic use_par, input logic pbit);
        RxD = 0; wait_ticks(16);
        for (int i = 0; i < 8; i++) begin RxD = d[i]; wait_ticks(16); end
        if (use_par) begin RxD = pbit; wait_ticks(16); end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit,
                              input logic s1, input logic s2, input int nstop);
        send_head(d, use_par, pbit);
        RxD = s1; wait_ticks(16);
        if (nstop == 2) begin RxD = s2; wait_ticks(16); end
        RxD = 1; wait_ticks(16);
    endtask

    task automatic test_reset;
        repeat (4) @(posedge clk);
        #1;
        cmp++; if ({rx_valid, RxData, Parity_error, Stop_error, overrun, break_det} !== 12'h0) begin bad++; $display("FAIL reset_outputs: got %h want 000", {rx_valid, RxData, Parity_error, Stop_error, overrun, break_det}); end
        reset = 1;
        wait_ticks(20);
    endtask

    task automatic test_basic;
        int a0 = acc_cnt;
        send_frame(8'hA5, 0, 0, 1, 1, 1);
        cmp++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", acc_cnt - a0); end
        cmp++; if (acc_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b00) begin bad++; $display("FAIL basic_errs: got %b want 00", {acc_perr, acc_serr}); end
    endtask

    task automatic test_parity;
        parity_mode = 2'b01;
        send_frame(8'h3C, 1, 1, 1, 1, 1);
        cmp++; if (acc_data !== 8'h3C) begin bad++; $display("FAIL even_data: got %h want 3c", acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b10) begin bad++; $display("FAIL even_errs: got %b want 10", {acc_perr, acc_serr}); end
        parity_mode = 2'b10;
        send_frame(8'h3C, 1, 1, 1, 1, 1);
        cmp++; if (acc_data !== 8'h3C) begin bad++; $display("FAIL odd_data: got %h want 3c", acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b00) begin bad++; $display("FAIL odd_errs: got %b want 00", {acc_perr, acc_serr}); end
        parity_mode = 2'b00;
    endtask

    task automatic test_two_stop_glitch;
        int a0, o0, b0;
        two_stop = 1;
        send_frame(8'h55, 0, 0, 1, 0, 2);
        two_stop = 0;
        cmp++; if (acc_data !== 8'h55) begin bad++; $display("FAIL two_stop_data: got %h want 55", acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b01) begin bad++; $display("FAIL two_stop_errs: got %b want 01", {acc_perr, acc_serr}); end
        wait_ticks(32);
        a0 = acc_cnt; o0 = ovr_cnt; b0 = brk_cnt;
        RxD = 0; wait_ticks(2);
        RxD = 1; wait_ticks(40);
        cmp++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL glitch_words: got %0d want 0", acc_cnt - a0); end
        cmp++; if ({ovr_cnt - o0, brk_cnt - b0} !== {32'd0, 32'd0}) begin bad++; $display("FAIL glitch_flags: got ovr %0d brk %0d want 0 0", ovr_cnt - o0, brk_cnt - b0); end
    endtask

    task automatic test_overrun;
        int a0 = acc_cnt, o0 = ovr_cnt;
        rx_ready = 0;
        send_frame(8'h11, 0, 0, 1, 1, 1);
        send_frame(8'h22, 0, 0, 1, 1, 1);
        cmp++; if ({rx_valid, RxData} !== {1'b1, 8'h11}) begin bad++; $display("FAIL ovr_hold: got %b/%h want 1/11", rx_valid, RxData); end
        cmp++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
        rx_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        cmp++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h11) begin bad++; $display("FAIL ovr_drain: got %0d/%h want 1/11", acc_cnt - a0, acc_data); end
        a0 = acc_cnt; o0 = ovr_cnt;
        rx_ready = 0;
        send_frame(8'h11, 0, 0, 1, 1, 1);
        send_head(8'h22, 0, 0);
        RxD = 1; wait_ticks(9);
        while (!baud_tick) begin @(posedge clk); #1; end
        rx_ready = 1;
        @(posedge clk); #1;
        cmp++; if ({rx_valid, RxData} !== {1'b1, 8'h22}) begin bad++; $display("FAIL ready_on_complete_load: got %b/%h want 1/22", rx_valid, RxData); end
        wait_ticks(23);
        cmp++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL ready_on_complete_ovr: got %0d want 0", ovr_cnt - o0); end
        cmp++; if (acc_cnt - a0 !== 2 || acc_data !== 8'h22) begin bad++; $display("FAIL ready_on_complete_words: got %0d/%h want 2/22", acc_cnt - a0, acc_data); end
    endtask

    task automatic test_break;
        int a0 = acc_cnt, b0 = brk_cnt;
        RxD = 0; wait_ticks(320);
        RxD = 1; wait_ticks(32);
        cmp++; if (brk_cnt - b0 !== 1) begin bad++; $display("FAIL break_pulse: got %0d want 1", brk_cnt - b0); end
        cmp++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL break_words: got %0d want 0", acc_cnt - a0); end
        send_frame(8'h7E, 0, 0, 1, 1, 1);
        cmp++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h7E) begin bad++; $display("FAIL after_break: got %0d/%h want 1/7e", acc_cnt - a0, acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b00) begin bad++; $display("FAIL after_break_errs: got %b want 00", {acc_perr, acc_serr}); end
    endtask

    task automatic test_reset_mid_frame;
        int a0 = acc_cnt;
        rx_ready = 0;
        send_frame(8'h33, 0, 0, 1, 1, 1);
        cmp++; if ({rx_valid, RxData} !== {1'b1, 8'h33}) begin bad++; $display("FAIL pre_reset_hold: got %b/%h want 1/33", rx_valid, RxData); end
        RxD = 0; wait_ticks(16);
        RxD = 1; wait_ticks(48);
        reset = 0;
        #1;
        cmp++; if ({rx_valid, RxData, Parity_error, Stop_error, overrun, break_det} !== 12'h0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 000", {rx_valid, RxData, Parity_error, Stop_error, overrun, break_det}); end
        repeat (5) @(posedge clk);
        #1;
        reset = 1;
        rx_ready = 1;
        wait_ticks(32);
        send_frame(8'h01, 0, 0, 1, 1, 1);
        cmp++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h01) begin bad++; $display("FAIL post_reset_word: got %0d/%h want 1/01", acc_cnt - a0, acc_data); end
    endtask

    task automatic test_noise;
        int a0 = acc_cnt;
        logic [7:0] d = 8'h0F;
        RxD = 0; wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];  wait_ticks(8);
            RxD = ~d[i]; wait_ticks(1);
            RxD = d[i];  wait_ticks(7);
        end
        RxD = 1; wait_ticks(32);
        cmp++; if (acc_cnt - a0 !== 1 || acc_data !== 8'h0F) begin bad++; $display("FAIL noise_word: got %0d/%h want 1/0f", acc_cnt - a0, acc_data); end
        cmp++; if ({acc_perr, acc_serr} !== 2'b00) begin bad++; $display("FAIL noise_errs: got %b want 00", {acc_perr, acc_serr}); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_two_stop_glitch;
        test_overrun;
        test_break;
        test_reset_mid_frame;
        test_noise;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
